riscv_pma_cfgregs: RTL
======================

RISCV_PMA_CFGREGS -- requirements
Module: riscv_pma_cfgregs

Interface
REQ-001 SHALL have parameter XLEN, default 32, register data width.
REQ-002 SHALL have parameter PMA_CNT, default 16, number of PMA entries (1..16).
REQ-003 SHALL have parameters PMA_CFG_INIT / PMA_ADR_INIT, default all-zero arrays [PMA_CNT], reset values of entries.
REQ-004 SHALL have ports: clk_i in 1 clock; rst_i in 1 reset, asynchronous, active-high.
REQ-005 SHALL have ports: req_i in 1 access request; we_i in 1 write; adr_i in 6 {bank[5:4], idx[3:0]}; d_i in XLEN write data.
REQ-006 SHALL have ports: q_o out XLEN read data; ack_o out 1 access done; err_o out 1 access rejected.
REQ-007 SHALL have ports: pma_cfg_o out pmacfg_t [PMA_CNT] active config; pma_adr_o out XLEN [PMA_CNT] active addresses; update_o out 1 active-set changed.

Function
REQ-008 SHALL hold two register sets per entry: shadow (bus-visible) and active (drives pma_cfg_o/pma_adr_o).
REQ-009 SHALL map banks: 0 = cfg[idx], 1 = adr[idx], 2 = control (idx 0 only), 3 = reserved.
REQ-010 SHALL pack cfg word as: [0]r [1]w [2]x [3]c [4]cc [5]ri [6]wi [7]m [9:8]a [11:10]mem_type [13:12]amo_type [31]L; other bits write-ignored, read 0.
REQ-011 SHALL sample req_i every cycle; ack_o asserts exactly one cycle after each sampled req_i, one-cycle pulse; back-to-back requests give back-to-back acks.
REQ-012 SHALL present q_o (shadow contents) and err_o in the ack_o cycle; q_o = 0 when ack_o low or err_o high.
REQ-013 SHALL set err_o with ack_o for idx >= PMA_CNT, bank 3, bank 2 idx != 0, or lock violation; rejected writes change no state.
REQ-014 SHALL treat entry i as locked when active cfg[i].L = 1; address i additionally locked when active cfg[i+1].L = 1 and active cfg[i+1].a = TOR.
REQ-015 SHALL reject (err_o) writes to locked cfg/adr shadow registers.
REQ-016 SHALL, on write to control with d_i[0] = 1, copy every unlocked shadow entry into active in the ack_o cycle; locked active entries are unchanged.
REQ-017 SHALL pulse update_o for one cycle, coincident with the commit ack_o, only if any active bit changed.
REQ-018 SHALL read control as: [0] 0, [1] shadow differs from active, [7:4] PMA_CNT-1.
REQ-019 SHALL update pma_cfg_o/pma_adr_o only at commit; shadow writes never affect outputs.
REQ-020 SHALL resolve lock state from active values before the commit in progress (commit setting L locks only subsequent accesses).

Reset
REQ-021 SHALL on rst_i asynchronously set shadow and active to PMA_CFG_INIT/PMA_ADR_INIT, ack_o = 0, err_o = 0, update_o = 0, q_o = 0; a pending access is discarded (no ack).
REQ-022 SHALL clear L bits only via reset (or init value).

Configuration
REQ-023 SHALL compile lock support with macro RV_PMA_LOCK_EN: defined -> REQ-014/015/016 lock behaviour; undefined -> L reads 0, writes to L ignored, no entry ever locked, err_o never raised for lock.

Verification
REQ-024 Reset with PMA_ADR_INIT[0] = 'h1000 -> pma_adr_o[0] = 'h1000, ack_o = 0, update_o = 0.
REQ-025 Write adr[2] = 'h2000_0000, read adr[2] -> q_o = 'h2000_0000, pma_adr_o[2] unchanged, control[1] = 1; commit -> pma_adr_o[2] = 'h2000_0000, update_o pulse one cycle.
REQ-026 Back-to-back reads on cycles n, n+1, n+2 -> ack_o high on n+1..n+3, err_o low.
REQ-027 Write cfg[3] = 'h8000_0301 (L, TOR, r), commit, then write adr[3] and adr[2] -> both ack with err_o = 1, values unchanged (with RV_PMA_LOCK_EN); without macro -> both accepted.
REQ-028 Access idx 15 with PMA_CNT = 8, and bank 3 -> err_o = 1, q_o = 0.
REQ-029 Commit with no shadow changes -> ack_o = 1, update_o = 0; rst_i asserted in cycle after req_i -> no ack_o.

Source files
------------

// File: rtl/riscv_pma_cfgregs.sv
// PMA configuration register file: bus-visible shadow set committed into an active set driving the PMA checker.
// Optional lock support under macro RV_PMA_LOCK_EN; one-cycle registered response to every request.
package riscv_pma_pkg;
   typedef struct packed {
      logic       l;
      logic [1:0] amo_type;
      logic [1:0] mem_type;
      logic [1:0] a;
      logic       m;
      logic       wi;
      logic       ri;
      logic       cc;
      logic       c;
      logic       x;
      logic       w;
      logic       r;
   } pmacfg_t;

   // Address-match mode value meaning "top of range" for this register layout
   localparam logic [1:0] PMA_A_TOR = 2'b11;
endpackage

module riscv_pma_cfgregs
   import riscv_pma_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int PMA_CNT = 16,
   parameter pmacfg_t [PMA_CNT-1:0]        PMA_CFG_INIT = '0,
   parameter logic [PMA_CNT-1:0][XLEN-1:0] PMA_ADR_INIT = '0
)(
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          req_i,
   input  logic                          we_i,
   input  logic [5:0]                    adr_i,
   input  logic [XLEN-1:0]               d_i,
   output logic [XLEN-1:0]               q_o,
   output logic                          ack_o,
   output logic                          err_o,
   output pmacfg_t [PMA_CNT-1:0]         pma_cfg_o,
   output logic [PMA_CNT-1:0][XLEN-1:0]  pma_adr_o,
   output logic                          update_o
);

`ifdef RV_PMA_LOCK_EN
   localparam logic LOCK_EN = 1'b1;
`else
   localparam logic LOCK_EN = 1'b0;
`endif

   typedef pmacfg_t [PMA_CNT-1:0] cfg_arr_t;

   function automatic cfg_arr_t strip_l(cfg_arr_t c);
      for (int i = 0; i < PMA_CNT; i++) c[i].l = c[i].l & LOCK_EN;
      return c;
   endfunction

   function automatic pmacfg_t word2cfg(logic [XLEN-1:0] w);
      return pmacfg_t'({w[31] & LOCK_EN, w[13:0]});
   endfunction

   function automatic logic [XLEN-1:0] cfg2word(pmacfg_t c);
      logic [XLEN-1:0] w;
      w       = '0;
      w[13:0] = c[13:0];
      w[31]   = c.l;
      return w;
   endfunction

   localparam cfg_arr_t CFG_RST = strip_l(PMA_CFG_INIT);

   cfg_arr_t                     sh_cfg_q, sh_cfg_d, ac_cfg_q, ac_cfg_d;
   logic [PMA_CNT-1:0][XLEN-1:0] sh_adr_q, sh_adr_d, ac_adr_q, ac_adr_d;
   logic                         ack_q, ack_d, err_q, err_d, upd_q, upd_d;
   logic [XLEN-1:0]              q_q, q_d;

   logic [PMA_CNT-1:0] ent_lock, adr_lock;
   logic [1:0]         bank;
   logic [3:0]         idx;
   logic               diff;
   logic [XLEN-1:0]    ctrl;

   // Locks always come from the active set as it stands before this access
   always_comb begin
      for (int i = 0; i < PMA_CNT; i++) begin
         ent_lock[i] = ac_cfg_q[i].l & LOCK_EN;
         adr_lock[i] = ac_cfg_q[i].l & LOCK_EN;
      end
      for (int i = 0; i < PMA_CNT-1; i++)
         adr_lock[i] = adr_lock[i] |
                       (LOCK_EN & ac_cfg_q[i+1].l & (ac_cfg_q[i+1].a == PMA_A_TOR));
   end

   always_comb begin
      sh_cfg_d = sh_cfg_q;
      sh_adr_d = sh_adr_q;
      ac_cfg_d = ac_cfg_q;
      ac_adr_d = ac_adr_q;
      ack_d    = req_i;
      err_d    = 1'b0;
      upd_d    = 1'b0;
      q_d      = '0;
      bank     = adr_i[5:4];
      idx      = adr_i[3:0];
      diff     = (sh_cfg_q != ac_cfg_q) || (sh_adr_q != ac_adr_q);
      ctrl      = '0;
      ctrl[1]   = diff;
      ctrl[7:4] = 4'(PMA_CNT-1);

      if (req_i) begin
         unique case (bank)
            2'd0, 2'd1: begin
               err_d = 1'b1;
               for (int i = 0; i < PMA_CNT; i++) begin
                  if (idx == 4'(i)) begin
                     if (bank == 2'd0) begin
                        if (!(we_i && ent_lock[i])) begin
                           err_d = 1'b0;
                           if (we_i) sh_cfg_d[i] = word2cfg(d_i);
                           q_d = cfg2word(sh_cfg_d[i]);
                        end
                     end else begin
                        if (!(we_i && adr_lock[i])) begin
                           err_d = 1'b0;
                           if (we_i) sh_adr_d[i] = d_i;
                           q_d = sh_adr_d[i];
                        end
                     end
                  end
               end
            end
            2'd2: begin
               if (idx != 4'd0) begin
                  err_d = 1'b1;
               end else begin
                  q_d = ctrl;
                  if (we_i && d_i[0]) begin
                     for (int i = 0; i < PMA_CNT; i++) begin
                        if (!ent_lock[i]) ac_cfg_d[i] = sh_cfg_q[i];
                        if (!adr_lock[i]) ac_adr_d[i] = sh_adr_q[i];
                     end
                     upd_d = (ac_cfg_d != ac_cfg_q) || (ac_adr_d != ac_adr_q);
                  end
               end
            end
            default: err_d = 1'b1;
         endcase
         if (err_d) q_d = '0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sh_cfg_q <= CFG_RST;
         ac_cfg_q <= CFG_RST;
         sh_adr_q <= PMA_ADR_INIT;
         ac_adr_q <= PMA_ADR_INIT;
         ack_q    <= 1'b0;
         err_q    <= 1'b0;
         upd_q    <= 1'b0;
         q_q      <= '0;
      end else begin
         sh_cfg_q <= sh_cfg_d;
         ac_cfg_q <= ac_cfg_d;
         sh_adr_q <= sh_adr_d;
         ac_adr_q <= ac_adr_d;
         ack_q    <= ack_d;
         err_q    <= err_d;
         upd_q    <= upd_d;
         q_q      <= q_d;
      end
   end

   assign q_o       = q_q;
   assign ack_o     = ack_q;
   assign err_o     = err_q;
   assign update_o  = upd_q;
   assign pma_cfg_o = ac_cfg_q;
   assign pma_adr_o = ac_adr_q;

endmodule
